// File: rtl/arm_mem_pkg.sv
// +----------------------------------------------------------------------+
// | arm_mem_pkg: shared encodings for the mem_arbiter slice.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// +----------------------------------------------------------------------+
// | mem_timeout_ctr: counts ISSUE cycles, flags the last allowed cycle.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturate at LAST so the count never wraps if the caller lingers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter: fetch/data arbiter sharing one memory port, with abort  |
// | on timeout. Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            next_state;
  logic              grant;
  logic              win;
  logic              take;
  logic              finish;
  logic              timed_out;
  logic              expired;
  logic [DATA_W-1:0] rdata_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GNT_D;
    end else if (take) begin
      last_grant <= win;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    win        = GNT_D;
    rdata_sel  = '0;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
          win = ~last_grant;
        end else begin
          win = d_req ? GNT_D : GNT_I;
        end
`else
        win = d_req ? GNT_D : GNT_I;
`endif
        if (i_req || d_req) begin
          take       = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        // An ack in the expiring cycle still completes cleanly.
        if (mem_ack) begin
          finish     = 1'b1;
          next_state = DONE;
          if (!mem_we) begin
            rdata_sel = mem_rdata;
          end
        end else if (expired) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (take),
    .enable  (state == ISSUE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= GNT_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      bus_err <= 1'b0;
      if (take) begin
        grant   <= win;
        mem_req <= 1'b1;
        if (win == GNT_D) begin
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= 4'b1111;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end
      if (finish) begin
        mem_req <= 1'b0;
        bus_err <= timed_out;
        if (grant == GNT_D) begin
          d_ack   <= 1'b1;
          d_rdata <= rdata_sel;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= rdata_sel;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter: randomized transaction-level check of mem_arbiter.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          i_req     = 1'b0;
  logic [AW-1:0] i_addr    = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req     = 1'b0;
  logic          d_we      = 1'b0;
  logic [3:0]    d_be      = '0;
  logic [AW-1:0] d_addr    = '0;
  logic [DW-1:0] d_wdata   = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack   = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: outstanding requests and who won the previous grant.
  bit pend_i = 1'b0;
  bit pend_d = 1'b0;
  bit last_d = 1'b1;
  string order = "";

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic raise_i(input logic [AW-1:0] a);
    i_req = 1'b1; i_addr = a; pend_i = 1'b1;
  endtask

  task automatic raise_d(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; pend_d = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check_val(tag, {28'd0, i_ack, d_ack, bus_err, mem_req}, 32'd0);
    check_val({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
  endtask

  // One transaction: memory acks in its (w+1)-th ISSUE cycle, or never if w >= TO.
  task automatic run_txn(input int w, input logic [DW-1:0] rd);
    bit            win_d;
    bit            tmo;
    int            e;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rd;
    if (pend_i && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !last_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = pend_d;
    end
    last_d   = win_d;
    order    = {order, win_d ? "D" : "I"};
    tmo      = (w >= TO);
    e        = tmo ? TO : w + 1;
    exp_we   = win_d ? d_we : 1'b0;
    exp_addr = win_d ? d_addr : i_addr;
    exp_rd   = (tmo || exp_we) ? '0 : rd;
    for (int k = 0; k < e; k++) begin
      @(negedge clk);
      check_val("mem_req", {31'd0, mem_req}, 32'd1);
      check_val("mem_addr", mem_addr, exp_addr);
      check_val("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (win_d) begin
        check_val("mem_be", {28'd0, mem_be}, {28'd0, d_be});
        check_val("mem_wdata", mem_wdata, d_wdata);
      end
      check_val("ack_early", {29'd0, i_ack, d_ack, bus_err}, 32'd0);
      mem_ack   = (k == w);
      mem_rdata = (k == w) ? rd : $urandom;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("mem_req_done", {31'd0, mem_req}, 32'd0);
    check_val("i_ack", {31'd0, i_ack}, {31'd0, !win_d});
    check_val("d_ack", {31'd0, d_ack}, {31'd0, win_d});
    check_val("i_rdata", i_rdata, win_d ? '0 : exp_rd);
    check_val("d_rdata", d_rdata, win_d ? exp_rd : '0);
    check_val("bus_err", {31'd0, bus_err}, {31'd0, tmo});
    if (win_d) begin
      d_req = 1'b0; pend_d = 1'b0;
    end else begin
      i_req = 1'b0; pend_i = 1'b0;
    end
    @(negedge clk);
    check_quiet("idle_after");
  endtask

  initial begin
    // Reset state
    #1;
    check_quiet("reset_async");
    repeat (2) @(negedge clk);
    check_quiet("reset_held");
    reset = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Zero-wait fetch
    raise_i(32'h10);
    run_txn(0, 32'hE3A05005);

    // Store with partial byte enables
    raise_d(1'b1, 4'b0011, 32'h80, 32'h0000000B);
    run_txn(1, 32'hDEADBEEF);

    // Three simultaneous requests with one-wait memory, then drain
    order = "";
    for (int r = 0; r < 3; r++) begin
      if (!pend_i) raise_i(32'h100 + 32'(r * 4));
      if (!pend_d) raise_d(1'b0, 4'hF, 32'h200 + 32'(r * 4), 32'h0);
      run_txn(1, $urandom);
    end
`ifdef ARB_ROUND_ROBIN_EN
    check_val("rr_order", {8'd0, order.getc(0), order.getc(1), order.getc(2)}, {8'd0, "IDI"});
`else
    check_val("fp_order", {8'd0, order.getc(0), order.getc(1), order.getc(2)}, {8'd0, "DDD"});
`endif
    while (pend_i || pend_d) run_txn(1, $urandom);

    // Timeout and the ack-wins-at-expiry boundary
    raise_d(1'b0, 4'hF, 32'h300, 32'h0);
    run_txn(TO + 3, 32'h12345678);
    raise_i(32'h304);
    run_txn(TO - 1, 32'hCAFEF00D);

    // Reset in the middle of ISSUE
    raise_i(32'h400);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("reset_mid_issue");
    i_req = 1'b0; pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("no_stale_ack");
    raise_i(32'h404);
    run_txn(0, 32'h0BADC0DE);

    // Randomized traffic
    for (int r = 0; r < 60; r++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) raise_i($urandom);
      if (!pend_d && $urandom_range(0, 1) == 1)
        raise_d($urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom);
      if (!pend_i && !pend_d) raise_i($urandom);
      run_txn(int'($urandom_range(0, 5)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
